// File: rtl/execute_stage_if.sv
// Bundle between the ID/EX register, the execute stage and the memory stage:
// E-side inputs and forwarding selects in, redirect and EX/MEM register contents out.
interface execute_stage_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [WIDTH-1:0]      pcE;
  logic [WIDTH-1:0]      data1E;
  logic [WIDTH-1:0]      data2E;
  logic [WIDTH-1:0]      ImmE;
  logic [3:0]            ALUCtrlE;
  logic                  ALUSrcE;
  logic                  BranchE;
  logic                  JumpE;
  logic                  RegWriteE;
  logic                  MemtoRegE;
  logic                  MemReadE;
  logic                  MemWriteE;
  logic                  one_byteE;
  logic                  two_byteE;
  logic                  four_bytesE;
  logic                  unsigned_loadE;
  logic [ADDR_WIDTH-1:0] RdE;
  logic [1:0]            ForwardAE;
  logic [1:0]            ForwardBE;
  logic [WIDTH-1:0]      ResultW;

  logic                  PCSrcE;
  logic [WIDTH-1:0]      PCTargetE;
  logic [WIDTH-1:0]      ALUResultM;
  logic [WIDTH-1:0]      WriteDataM;
  logic [WIDTH-1:0]      PCPlus4M;
  logic [ADDR_WIDTH-1:0] RdM;
  logic                  RegWriteM;
  logic                  MemtoRegM;
  logic                  MemReadM;
  logic                  MemWriteM;
  logic                  one_byteM;
  logic                  two_byteM;
  logic                  four_bytesM;
  logic                  unsigned_loadM;

  modport master (
    output pcE, data1E, data2E, ImmE, ALUCtrlE, ALUSrcE, BranchE, JumpE,
           RegWriteE, MemtoRegE, MemReadE, MemWriteE,
           one_byteE, two_byteE, four_bytesE, unsigned_loadE,
           RdE, ForwardAE, ForwardBE, ResultW,
    input  PCSrcE, PCTargetE, ALUResultM, WriteDataM, PCPlus4M, RdM,
           RegWriteM, MemtoRegM, MemReadM, MemWriteM,
           one_byteM, two_byteM, four_bytesM, unsigned_loadM
  );

  modport slave (
    input  pcE, data1E, data2E, ImmE, ALUCtrlE, ALUSrcE, BranchE, JumpE,
           RegWriteE, MemtoRegE, MemReadE, MemWriteE,
           one_byteE, two_byteE, four_bytesE, unsigned_loadE,
           RdE, ForwardAE, ForwardBE, ResultW,
    output PCSrcE, PCTargetE, ALUResultM, WriteDataM, PCPlus4M, RdM,
           RegWriteM, MemtoRegM, MemReadM, MemWriteM,
           one_byteM, two_byteM, four_bytesM, unsigned_loadM
  );
endinterface

// File: rtl/execute_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution with
// combinational PC redirect, and the EX/MEM pipeline register.
module execute_stage #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input logic           clk,
  input logic           rst,
  execute_stage_if.slave ex
);
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] fwd_b;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] jalr_sum;
  logic [WIDTH-1:0] result_sel;
  logic [4:0]       shamt;
  logic             branch_cond;

  logic [WIDTH-1:0]      alu_result_reg;
  logic [WIDTH-1:0]      write_data_reg;
  logic [WIDTH-1:0]      pc_plus4_reg;
  logic [ADDR_WIDTH-1:0] rd_reg;
  logic [7:0]            ctrl_reg;

  // 10 forwards the instruction one ahead (EX/MEM), 01 the one two ahead (writeback).
  always_comb begin
    case (ex.ForwardAE)
      2'b10:   src_a = ex.ALUResultM;
      2'b01:   src_a = ex.ResultW;
      default: src_a = ex.data1E;
    endcase
    case (ex.ForwardBE)
      2'b10:   fwd_b = ex.ALUResultM;
      2'b01:   fwd_b = ex.ResultW;
      default: fwd_b = ex.data2E;
    endcase
    src_b = ex.ALUSrcE ? ex.ImmE : fwd_b;
    shamt = src_b[4:0];
  end

  always_comb begin
    case (ex.ALUCtrlE)
      4'b0000: alu_result = src_a + src_b;
      4'b0001: alu_result = src_a - src_b;
      4'b0010: alu_result = src_a & src_b;
      4'b0011: alu_result = src_a | src_b;
      4'b0100: alu_result = src_a ^ src_b;
      4'b0101: alu_result = src_a << shamt;
      4'b0110: alu_result = src_a >> shamt;
      4'b0111: alu_result = $unsigned($signed(src_a) >>> shamt);
      4'b1000: alu_result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      4'b1001: alu_result = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
      4'b1010: alu_result = src_b;
      default: alu_result = '0;
    endcase
  end

  // Branches compare against the forwarded rs2, never the immediate.
  always_comb begin
    case (ex.ALUCtrlE)
      4'b0001: branch_cond = (src_a == fwd_b);
      4'b1011: branch_cond = (src_a != fwd_b);
      4'b1000: branch_cond = ($signed(src_a) <  $signed(fwd_b));
      4'b1100: branch_cond = ($signed(src_a) >= $signed(fwd_b));
      4'b1001: branch_cond = (src_a <  fwd_b);
      4'b1101: branch_cond = (src_a >= fwd_b);
      default: branch_cond = 1'b0;
    endcase
  end

  always_comb begin
    pc_plus4   = ex.pcE + WIDTH'(4);
    jalr_sum   = src_a + ex.ImmE;
    result_sel = ex.JumpE ? pc_plus4 : alu_result;
  end

  assign ex.PCSrcE    = (ex.BranchE & branch_cond) | ex.JumpE;
  assign ex.PCTargetE = (ex.JumpE & ex.ALUSrcE) ? {jalr_sum[WIDTH-1:1], 1'b0}
                                                 : (ex.pcE + ex.ImmE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_result_reg <= '0;
      write_data_reg <= '0;
      pc_plus4_reg   <= '0;
      rd_reg         <= '0;
      ctrl_reg       <= '0;
    end else begin
      alu_result_reg <= result_sel;
      write_data_reg <= fwd_b;
      pc_plus4_reg   <= pc_plus4;
      rd_reg         <= ex.RdE;
      ctrl_reg       <= {ex.RegWriteE, ex.MemtoRegE, ex.MemReadE, ex.MemWriteE,
                         ex.one_byteE, ex.two_byteE, ex.four_bytesE, ex.unsigned_loadE};
    end
  end

  assign ex.ALUResultM     = alu_result_reg;
  assign ex.WriteDataM     = write_data_reg;
  assign ex.PCPlus4M       = pc_plus4_reg;
  assign ex.RdM            = rd_reg;
  assign ex.RegWriteM      = ctrl_reg[7];
  assign ex.MemtoRegM      = ctrl_reg[6];
  assign ex.MemReadM       = ctrl_reg[5];
  assign ex.MemWriteM      = ctrl_reg[4];
  assign ex.one_byteM      = ctrl_reg[3];
  assign ex.two_byteM      = ctrl_reg[2];
  assign ex.four_bytesM    = ctrl_reg[1];
  assign ex.unsigned_loadM = ctrl_reg[0];
endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the 5-stage RV32I pipeline, consuming the outputs of the ID/EX pipeline register. It applies operand forwarding, performs the ALU operation, resolves branches and jumps, and drives the PC redirect. Results are captured in an internal EX/MEM pipeline register that feeds the memory stage.

## Interface
**Parameters**
- WIDTH, 32, datapath width.
- ADDR_WIDTH, 5, register address width.

**Ports**
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- pcE, data1E, data2E, ImmE  in  WIDTH  from ID/EX: PC, rs1 value, rs2 value, immediate.
- ALUCtrlE  in  4  ALU/compare select.
- ALUSrcE, BranchE, JumpE  in  1 each  from ID/EX.
- RegWriteE, MemtoRegE, MemReadE, MemWriteE  in  1 each  from ID/EX.
- one_byteE, two_byteE, four_bytesE, unsigned_loadE  in  1 each  from ID/EX.
- RdE  in  ADDR_WIDTH  destination register.
- ForwardAE, ForwardBE  in  2  forwarding selects from the hazard unit.
- ResultW  in  WIDTH  writeback-stage result.
- PCSrcE  out  1  redirect taken; combinational.
- PCTargetE  out  WIDTH  redirect address; combinational.
- ALUResultM, WriteDataM, PCPlus4M  out  WIDTH  registered.
- RdM  out  ADDR_WIDTH  registered.
- RegWriteM, MemtoRegM, MemReadM, MemWriteM, one_byteM, two_byteM, four_bytesM, unsigned_loadM  out  1 each  registered.

## Operation
- **Forwarding.** SrcA uses ForwardAE: 00 selects data1E, 10 selects ALUResultM, 01 selects ResultW, 11 selects data1E. ForwardBE selects the forwarded rs2 value (FwdB) the same way from data2E. SrcB = ALUSrcE ? ImmE : FwdB.
- **ALUCtrlE encoding** (result → ALUResult):
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL, 0110 SRL, 0111 SRA; shift amount is SrcB[4:0].
  - 1000 SLT (signed), 1001 SLTU; result is zero-extended 0/1.
  - 1010 PASSB (LUI).
  - Any other code yields 0.
- **Branch compare**, valid only when BranchE=1, always on SrcA vs FwdB:
  - 0001 BEQ, 1011 BNE.
  - 1000 BLT, 1100 BGE (signed).
  - 1001 BLTU, 1101 BGEU (unsigned).
  - Any other code is not taken.
- **Redirect.**
  - PCSrcE = (BranchE & cond) | JumpE.
  - PCTargetE = (JumpE & ALUSrcE) ? ((SrcA + ImmE) & ~1) : (pcE + ImmE). The first case is JALR, the second is branch or JAL.
  - When PCSrcE=0, PCTargetE is don't-care but must not be X.
- **Link value.** When JumpE=1, the registered ALUResultM is pcE+4 instead of the ALU output.
- All arithmetic is modulo 2^WIDTH; overflow is ignored.
- **EX/MEM register** (async reset, otherwise loads every cycle; no stall or flush input):
  - ALUResultM ← selected result.
  - WriteDataM ← FwdB.
  - PCPlus4M ← pcE+4.
  - RdM and all control bits ← their E inputs.
- A bubble arriving from ID/EX (all zeros) propagates as a harmless NOP: RegWriteM=0, MemWriteM=0.

## Timing
- **Reset.** While rst=1, every M output is 0, asynchronously, independent of clk. The first capture happens on the first rising edge after rst falls.
- **Latency.** E inputs appear at the M outputs exactly 1 cycle later.
- **Combinational outputs.** PCSrcE and PCTargetE are valid in the same cycle as the E inputs. The external IF/ID and ID/EX flush logic uses them before the next edge.
- **Forwarding timing.** The 10 path uses the current ALUResultM, i.e. the instruction one ahead. The 01 path uses ResultW from the instruction two ahead.
- **Reset mid-stream.** Reset during a taken branch clears the M outputs immediately. PCSrcE still follows its inputs; gating it is the responsibility of upstream reset.

## Test plan
- **Reset.** Assert rst mid-cycle with nonzero E inputs → all M outputs 0 with no clock edge; after release, first edge captures the inputs.
- **ADD/SUB/SRA.**
  - ADD: data1E=0x7FFFFFFF, data2E=1, ALUCtrlE=0000 → ALUResultM=0x80000000 next cycle.
  - SUB: 5−7 → 0xFFFFFFFE.
  - SRA: 0x80000000 by ImmE=4 with ALUSrcE=1 → 0xF8000000.
- **Forwarding.**
  - Previous result ALUResultM=0x10, ForwardAE=10, data1E=0, ImmE=4, ALUSrcE=1, ADD → next ALUResultM=0x14.
  - With ForwardBE=01 and ResultW=0xAB, MemWriteE=1 → WriteDataM=0xAB.
- **Branches.**
  - BLT with SrcA=0xFFFFFFFF, FwdB=1, pcE=0x100, ImmE=0x20 → PCSrcE=1, PCTargetE=0x120.
  - Same operands with BLTU → PCSrcE=0.
- **JAL/JALR.**
  - JumpE=1, ALUSrcE=1, data1E=0x203, ImmE=4, pcE=0x40 → PCTargetE=0x206, PCSrcE=1, next ALUResultM=0x44.
  - With ALUSrcE=0 → PCTargetE=0x44.
- **Bubble.** All-zero E inputs after a store → RegWriteM=0, MemWriteM=0, RdM=0 next cycle.
